// File: rtl/mul_4b_seq.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One ripple-carry addition per cycle. The result and zero flag are held
// until the next operation completes.

// Single-bit full adder cell used to build the ripple chain.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  // Sum and carry of three input bits.
  always_comb begin
    s_o = a_i ^ b_i ^ c_i;
    c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end
endmodule

// WIDTH-bit ripple-carry adder. The carry-in of the chain is tied to 0.
module ripple_add #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;
  assign cout_o   = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i]),
      .s_o (sum_o[i]),
      .c_o (carry[i+1])
    );
  end
endmodule

// Multiplier controller and datapath around the ripple adder.
module mul_4b_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 zero_q, zero_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   shifted;

  // The multiplier's LSB selects whether the multiplicand is added this step.
  assign addend = acc_lo_q[0] ? mcand_q : '0;

  ripple_add #(.WIDTH(WIDTH)) u_add (
    .a_i    (acc_hi_q),
    .b_i    (addend),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // {cout, sum, acc_lo} shifted right by one: the carry lands in the MSB and
  // the bit shifted out of acc_lo is the multiplier bit just consumed.
  assign shifted = {cout, sum, acc_lo_q[WIDTH-1:1]};

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    zero_d    = zero_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = a;
          acc_lo_d = b;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_hi_d = shifted[2*WIDTH-1:WIDTH];
        acc_lo_d = shifted[WIDTH-1:0];
        if (cnt_q == CNT_LAST) begin
          // Last step: publish the full product; the count stops here.
          product_d = shifted;
          zero_d    = (shifted == '0);
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, so update order inside the block does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      zero_q    <= zero_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_mul_4b_seq.sv
// Directed self-checking bench for mul_4b_seq (WIDTH = 4).
module tb_mul_4b_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic       zero;

  int n_total  = 0;
  int n_passed = 0;

  mul_4b_seq #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so sampling and driving are away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Step until done is seen or the cycle budget runs out.
  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
  endtask

  // Start one operation from IDLE or DONE and check the published result.
  task automatic run_op(input logic [3:0] aa, input logic [3:0] bb, input string tag);
    logic [7:0] exp_p;
    exp_p = 8'(aa) * 8'(bb);
    a = aa; b = bb; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check({tag, "_done"}, 16'(done), 16'd1);
    check({tag, "_prod"}, 16'(product), 16'(exp_p));
    check({tag, "_zero"}, 16'(zero), 16'(exp_p == 8'd0));
  endtask

  initial begin
    int pulses;
    int done_at;
    logic [7:0] seen;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_prod", 16'(product), 16'h00);
    check("rst_zero", 16'(zero), 16'd1);
    rst = 1'b0;
    tick();

    // F*F: busy for four cycles, done on the fifth, max product.
    a = 4'hF; b = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ff_busy%0d", i), 16'(busy), 16'd1);
      check($sformatf("ff_nodone%0d", i), 16'(done), 16'd0);
      tick();
    end
    check("ff_done", 16'(done), 16'd1);
    check("ff_busy_lo", 16'(busy), 16'd0);
    check("ff_prod", 16'(product), 16'hE1);
    check("ff_zero", 16'(zero), 16'd0);
    tick();
    check("ff_done_once", 16'(done), 16'd0);
    check("ff_prod_held", 16'(product), 16'hE1);

    run_op(4'h0, 4'h9, "z09");
    check("z09_val", 16'(product), 16'h00);
    tick();
    run_op(4'h7, 4'h3, "m73");
    check("m73_val", 16'(product), 16'h15);
    tick();

    // Start during RUN is ignored; operand changes do not disturb the run.
    a = 4'h5; b = 4'h6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'hF; b = 4'hF; start = 1'b1;
    tick();
    start = 1'b0; a = 4'h3; b = 4'h1;
    pulses = 0; done_at = -1; seen = '0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) begin
        pulses++;
        if (done_at < 0) begin
          done_at = i;
          seen = product;
        end
      end
      tick();
    end
    check("ign_pulses", 16'(pulses), 16'd1);
    check("ign_when", 16'(done_at), 16'd2);
    check("ign_prod", 16'(seen), 16'h1E);

    // Back-to-back: start in the DONE cycle is accepted with no idle gap.
    a = 4'h2; b = 4'h3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("b2b_busy1", 16'(busy), 16'd1);
    tick();
    check("b2b_done1", 16'(done), 16'd1);
    check("b2b_prod1", 16'(product), 16'h06);
    a = 4'h9; b = 4'h9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_run%0d", i), 16'({busy, done}), 16'b10);
      check($sformatf("b2b_hold%0d", i), 16'(product), 16'h06);
      tick();
    end
    check("b2b_done2", 16'(done), 16'd1);
    check("b2b_prod2", 16'(product), 16'h51);
    tick();

    // Reset mid-RUN discards the operation and clears outputs at once.
    run_op(4'h3, 4'h3, "m33");
    tick();
    a = 4'hF; b = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mrst_busy", 16'(busy), 16'd0);
    check("mrst_done", 16'(done), 16'd0);
    check("mrst_prod", 16'(product), 16'h00);
    check("mrst_zero", 16'(zero), 16'd1);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      tick();
    end
    check("mrst_quiet", 16'(pulses), 16'd0);
    check("mrst_prod_kept", 16'(product), 16'h00);

    // Exhaustive sweep with back-to-back starts taken in each DONE cycle.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(4'(i), 4'(j), $sformatf("sw_%0d_%0d", i, j));
      end
    end
    tick();

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

  // Global bound so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
